comb_lock_param: RTL

COMB_LOCK_PARAM -- requirements
Module: comb_lock_param

---
 rtl/comb_lock_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/comb_lock_param.sv
// Parameterised combination lock with press-edge detection, wrong-try lockout and relock.
// Define COMB_LOCK_PROG_EN to make the code writable while open; otherwise it is fixed at DEFAULT_CODE.
module comb_lock_param #(
  parameter int SW_W = 3,
  parameter int CODE_LEN = 4,
  parameter logic [SW_W*CODE_LEN-1:0] DEFAULT_CODE = 12'b101_110_011_101,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 16,
  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1,
  localparam int PROG_W = $clog2(CODE_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   switch,
  input  logic              relock,
  input  logic              code_we,
  input  logic [IDX_W-1:0]  code_idx,
  input  logic [SW_W-1:0]   code_data,
  output logic              led,
  output logic              alarm,
  output logic [PROG_W-1:0] progress
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [SW_W-1:0] IDLE = '1;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [PROG_W-1:0]   progress_reg, progress_next;
  logic [FAIL_W-1:0]   fail_reg, fail_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [SW_W-1:0]     sw_reg;
  logic                press;
  logic [SW_W-1:0]     exp_sym;
  logic [SW_W*CODE_LEN-1:0] code_flat;
  logic [SW_W-1:0]     code_sym [CODE_LEN];

  // A press is the first non-idle sample after an idle one, so a held switch counts once.
  assign press = (switch != IDLE) && (sw_reg == IDLE);

`ifdef COMB_LOCK_PROG_EN
  logic wr_en;
  assign wr_en = (state_reg == OPEN) && code_we && (32'(code_idx) < CODE_LEN) && (code_data != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      code_flat <= DEFAULT_CODE;
    end else if (wr_en) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        if (32'(code_idx) == i) code_flat[SW_W*(CODE_LEN-i)-1 -: SW_W] <= code_data;
      end
    end
  end
`else
  logic unused_prog;
  assign unused_prog = ^{code_we, code_idx, code_data};
  assign code_flat   = DEFAULT_CODE;
`endif

  // Symbol 0 lives in the most significant slice.
  generate
    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_sym
      assign code_sym[gi] = code_flat[SW_W*(CODE_LEN-gi)-1 -: SW_W];
    end
  endgenerate

  always_comb begin
    exp_sym = code_sym[0];
    for (int i = 1; i < CODE_LEN; i++) begin
      if (progress_reg == PROG_W'(i)) exp_sym = code_sym[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LOCKED;
      progress_reg <= '0;
      fail_reg     <= '0;
      cnt_reg      <= '0;
      sw_reg       <= IDLE;
    end else begin
      state_reg    <= state_next;
      progress_reg <= progress_next;
      fail_reg     <= fail_next;
      cnt_reg      <= cnt_next;
      sw_reg       <= switch;
    end
  end

  always_comb begin
    state_next    = state_reg;
    progress_next = progress_reg;
    fail_next     = fail_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      LOCKED, ENTRY: begin
        if (press) begin
          if (switch == exp_sym) begin
            if (progress_reg == PROG_W'(CODE_LEN - 1)) begin
              state_next    = OPEN;
              progress_next = '0;
              fail_next     = '0;
            end else begin
              state_next    = ENTRY;
              progress_next = progress_reg + 1'b1;
            end
          end else begin
            progress_next = '0;
            if (fail_reg == FAIL_W'(MAX_TRIES - 1)) begin
              state_next = LOCKOUT;
              fail_next  = FAIL_W'(MAX_TRIES);
              cnt_next   = CNT_W'(LOCKOUT_CYC - 1);
            end else begin
              state_next = LOCKED;
              fail_next  = fail_reg + 1'b1;
            end
          end
        end
      end
      // Any press while open only relocks; it is never taken as a code symbol.
      OPEN: begin
        if (relock || press) state_next = LOCKED;
      end
      LOCKOUT: begin
        if (cnt_reg == '0) begin
          state_next = LOCKED;
          fail_next  = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next    = LOCKED;
        progress_next = '0;
        fail_next     = '0;
        cnt_next      = '0;
      end
    endcase
  end

  assign led      = (state_reg == OPEN);
  assign alarm    = (state_reg == LOCKOUT);
  assign progress = progress_reg;

endmodule
